// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs big-endian bytes into 32-bit words and writes them
// to an instruction memory port, flagging truncated programs and memory overflow.
module instr_loader #(
   parameter int unsigned MEM_SIZE = 1024,
   localparam int unsigned CW = $clog2(MEM_SIZE / 4) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   input  logic          byte_last,
   output logic          byte_ready,
   output logic          imem_we,
   output logic [63:0]   imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [CW-1:0] words_written
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_t;

   localparam logic [CW-1:0] MaxWords = CW'(MEM_SIZE / 4);

   state_t        state_q;
   logic [1:0]    byte_cnt_q;
   logic [CW-1:0] word_index_q;
   logic [CW-1:0] words_written_q;
   logic [23:0]   asm_q;
   logic          we_q;
   logic [63:0]   addr_q;
   logic [31:0]   wdata_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         byte_cnt_q      <= 2'd0;
         word_index_q    <= '0;
         words_written_q <= '0;
         asm_q           <= 24'd0;
         we_q            <= 1'b0;
         addr_q          <= 64'd0;
         wdata_q         <= 32'd0;
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone, StErr: begin
               if (start) begin
                  state_q         <= StLoad;
                  byte_cnt_q      <= 2'd0;
                  word_index_q    <= '0;
                  words_written_q <= '0;
                  asm_q           <= 24'd0;
               end
            end
            StLoad: begin
               if (byte_valid) begin
                  if (word_index_q >= MaxWords) begin
                     state_q <= StErr;
                  end else if (byte_cnt_q == 2'd3) begin
                     we_q            <= 1'b1;
                     addr_q          <= 64'({word_index_q, 2'b00});
                     wdata_q         <= {asm_q, byte_data};
                     word_index_q    <= word_index_q + 1'b1;
                     words_written_q <= words_written_q + 1'b1;
                     byte_cnt_q      <= 2'd0;
                     if (byte_last) state_q <= StDone;
                  end else begin
                     case (byte_cnt_q)
                        2'd0:    asm_q[23:16] <= byte_data;
                        2'd1:    asm_q[15:8]  <= byte_data;
                        default: asm_q[7:0]   <= byte_data;
                     endcase
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                     if (byte_last) state_q <= StErr;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Gate with reset so a write strobed by the last byte never commits on a reset edge.
   assign imem_we       = we_q & reset_n;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign byte_ready    = (state_q == StLoad);
   assign busy          = (state_q == StLoad);
   assign done          = (state_q == StDone);
   assign error         = (state_q == StErr);
   assign words_written = words_written_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter MEM_SIZE, default 1024, byte capacity of the target instruction memory; power of two, >4.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 start  input  1  single-cycle pulse beginning a load at byte address 0.
REQ-005 byte_valid  input  1  byte_data holds a valid byte this cycle.
REQ-006 byte_data  input  8  stream byte.
REQ-007 byte_last  input  1  qualifies byte_valid; marks the final byte of the program.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  one-cycle write strobe to the instruction memory write port.
REQ-010 imem_addr  output  64  byte address of the write, always word-aligned (bits [1:0]=0).
REQ-011 imem_wdata  output  32  assembled instruction word.
REQ-012 busy  output  1  high in LOAD.
REQ-013 done  output  1  high in DONE.
REQ-014 error  output  1  high in ERR.
REQ-015 words_written  output  $clog2(MEM_SIZE/4)+1  count of words written in the current or last load.

Function
REQ-016 FSM states: IDLE, LOAD, DONE, ERR; a byte is accepted only when byte_valid && byte_ready.
REQ-017 IDLE: byte_ready=0; start -> LOAD, clearing byte counter, word index, words_written, and the assembly register.
REQ-018 LOAD: byte_ready=1 every cycle; one byte accepted per cycle maximum, no bubbles required.
REQ-019 Byte order: first accepted byte of a word -> bits [31:24], second [23:16], third [15:8], fourth [7:0].
REQ-020 On the 4th accepted byte of a word, imem_we SHALL pulse high for exactly one cycle on the following cycle, with imem_addr = word_index*4 and imem_wdata = the complete word.
REQ-021 word_index and words_written increment in the same cycle imem_we is high; byte counter wraps 3->0.
REQ-022 byte_last accepted as the 4th byte of a word: the word is written per REQ-020, then DONE.
REQ-023 byte_last accepted on byte 1-3 of a word: no write of the partial word; -> ERR.
REQ-024 Overflow: a byte accepted when word_index*4 >= MEM_SIZE SHALL NOT cause a write; -> ERR.
REQ-025 DONE and ERR: byte_ready=0, imem_we=0; remain until start, which behaves as in REQ-017.
REQ-026 start while in LOAD SHALL be ignored.
REQ-027 byte_valid without byte_ready SHALL be ignored; no byte consumed.
REQ-028 imem_we SHALL never be high in IDLE, DONE, or ERR except the single trailing pulse of REQ-020/022 in the cycle DONE is entered.
REQ-029 imem_addr and imem_wdata hold their last values when imem_we=0.

Reset
REQ-030 reset_n=0 at a posedge -> state IDLE, byte counter 0, word_index 0, words_written 0, imem_we 0, imem_addr 0, imem_wdata 0, byte_ready 0, busy 0, done 0, error 0.
REQ-031 Reset mid-LOAD abandons the load; a write pending from the 4th byte SHALL NOT issue.
REQ-032 Reset has priority over start and byte handshakes in the same cycle.

Verification
REQ-033 start, then bytes 8B,1F,03,E0 back-to-back, last on E0 -> one imem_we pulse, addr 0, wdata 32'h8B1F03E0; done=1, words_written=1.
REQ-034 start, 12 bytes with byte_valid toggled every other cycle, last on byte 12 -> three writes at addrs 0,4,8 in order, done=1, words_written=3.
REQ-035 start, 6 bytes, last on byte 6 -> one write at addr 0, no write at addr 4, error=1, words_written=1.
REQ-036 MEM_SIZE=16, 20 bytes -> writes at 0,4,8,12; byte 17 -> error=1, no write at addr 16, byte_ready=0.
REQ-037 reset_n=0 the cycle after the 4th byte of word 2 -> no write at addr 4, all outputs at reset values, next start reloads from addr 0.
REQ-038 start asserted during LOAD and byte_valid in IDLE -> no effect on counters, addresses, or writes.
